link_rx_b: RTL

//  Serial receiver for the inter-board link. Slave board (player B) streams its

---
 rtl/link_rx_b.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/link_rx_b.sv
// Inter-board link receiver: deserialises player B's 21-bit status word
// (start, 21 data LSB first, even parity, stop) and holds it on registered outputs.
module link_rx_b #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_CYC  = 2000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rx,
    output logic [15:0] B,
    output logic        BTN1B,
    output logic        BTN2B,
    output logic        BTN3B,
    output logic        LivB,
    output logic        OKB,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        link_up
);

    localparam int unsigned PW = 21;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = 5;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(PW - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic          rx_m, rx_s;
    logic [2:0]    state, state_nxt;
    logic [CW-1:0] clk_cnt, clk_cnt_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt;
    logic [PW-1:0] shift, shift_nxt;
    logic          par_bit, par_bit_nxt;
    logic [TW-1:0] to_cnt;
    logic          good_c, bad_c;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            par_bit <= par_bit_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt + CW'(1);
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        par_bit_nxt = par_bit;
        good_c      = 1'b0;
        bad_c       = 1'b0;
        case (state)
            S_IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt   = S_START;
                    bit_cnt_nxt = '0;
                end
            end
            S_START: begin
                // Re-check mid start bit; a short glitch falls back silently
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_s, shift[PW-1:1]};
                    bit_cnt_nxt = bit_cnt + BW'(1);
                    if (bit_cnt == DATA_LAST) begin
                        state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    par_bit_nxt = rx_s;
                    state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    if (rx_s) begin
                        good_c    = ~(^{shift, par_bit});
                        bad_c     = ^{shift, par_bit};
                        state_nxt = S_IDLE;
                    end else begin
                        bad_c     = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                clk_cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                clk_cnt_nxt = '0;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    // Output word, pulses and link-loss supervision
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            B           <= '0;
            BTN1B       <= 1'b0;
            BTN2B       <= 1'b0;
            BTN3B       <= 1'b0;
            LivB        <= 1'b1;
            OKB         <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            link_up     <= 1'b0;
            to_cnt      <= '0;
        end else begin
            frame_valid <= good_c;
            frame_err   <= bad_c;
            if (good_c) begin
                {OKB, LivB, BTN3B, BTN2B, BTN1B, B} <= shift;
                link_up <= 1'b1;
                to_cnt  <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                // Stale link: drop momentary controls, keep positions and alive flag
                link_up <= 1'b0;
                BTN1B   <= 1'b0;
                BTN2B   <= 1'b0;
                BTN3B   <= 1'b0;
                OKB     <= 1'b0;
            end
        end
    end

endmodule
